// File: rtl/oc_alu_collector_if.sv
// Issue-stage, register-file read port and ALU dispatch bundle for oc_alu_collector.
// master = collector view, slave = surrounding pipeline view.
interface oc_alu_collector_if;
   logic         Valid_IB_OC;
   logic         Ready_OC_IB;
   logic [2:0]   WarpID_IB_OC;
   logic [31:0]  Instr_IB_OC;
   logic [7:0]   ActiveMask_IB_OC;
   logic [4:0]   Src1_IB_OC;
   logic         Src1_Used_IB_OC;
   logic [4:0]   Src2_IB_OC;
   logic         Src2_Used_IB_OC;
   logic [4:0]   Dst_IB_OC;
   logic [15:0]  Imme_IB_OC;
   logic         Imme_Valid_IB_OC;
   logic         RegWrite_IB_OC;
   logic [3:0]   ALUop_IB_OC;
   logic         BEQ_IB_OC;
   logic         BLT_IB_OC;
   logic [1:0]   ScbID_IB_OC;

   logic         RFReq_Valid_OC_RF;
   logic [2:0]   RFReq_WarpID_OC_RF;
   logic [4:0]   RFReq_Addr_OC_RF;
   logic         RFGrant_RF_OC;
   logic [255:0] RFRsp_Data_RF_OC;

   logic         Valid_OC_ALU;
   logic [7:0]   ActiveMask_OC_ALU;
   logic [2:0]   WarpID_OC_ALU;
   logic [31:0]  Instr_OC_ALU;
   logic [255:0] Src1_Data_OC_ALU;
   logic [255:0] Src2_Data_OC_ALU;
   logic [4:0]   Dst_OC_ALU;
   logic [15:0]  Imme_OC_ALU;
   logic         Imme_Valid_OC_ALU;
   logic         RegWrite_OC_ALU;
   logic [3:0]   ALUop_OC_ALU;
   logic         BEQ_OC_ALU;
   logic         BLT_OC_ALU;
   logic [1:0]   ScbID_OC_ALU;

   // Issue: transfer on Valid_IB_OC & Ready_OC_IB at a clock edge; Ready depends
   // on collector state only. RF: request held until RFGrant_RF_OC, data returns
   // the cycle after the grant. ALU: Valid_OC_ALU is a one-cycle strobe, no backpressure.
   modport master (
      input  Valid_IB_OC, WarpID_IB_OC, Instr_IB_OC, ActiveMask_IB_OC,
             Src1_IB_OC, Src1_Used_IB_OC, Src2_IB_OC, Src2_Used_IB_OC,
             Dst_IB_OC, Imme_IB_OC, Imme_Valid_IB_OC, RegWrite_IB_OC,
             ALUop_IB_OC, BEQ_IB_OC, BLT_IB_OC, ScbID_IB_OC,
             RFGrant_RF_OC, RFRsp_Data_RF_OC,
      output Ready_OC_IB,
             RFReq_Valid_OC_RF, RFReq_WarpID_OC_RF, RFReq_Addr_OC_RF,
             Valid_OC_ALU, ActiveMask_OC_ALU, WarpID_OC_ALU, Instr_OC_ALU,
             Src1_Data_OC_ALU, Src2_Data_OC_ALU, Dst_OC_ALU, Imme_OC_ALU,
             Imme_Valid_OC_ALU, RegWrite_OC_ALU, ALUop_OC_ALU,
             BEQ_OC_ALU, BLT_OC_ALU, ScbID_OC_ALU
   );

   modport slave (
      output Valid_IB_OC, WarpID_IB_OC, Instr_IB_OC, ActiveMask_IB_OC,
             Src1_IB_OC, Src1_Used_IB_OC, Src2_IB_OC, Src2_Used_IB_OC,
             Dst_IB_OC, Imme_IB_OC, Imme_Valid_IB_OC, RegWrite_IB_OC,
             ALUop_IB_OC, BEQ_IB_OC, BLT_IB_OC, ScbID_IB_OC,
             RFGrant_RF_OC, RFRsp_Data_RF_OC,
      input  Ready_OC_IB,
             RFReq_Valid_OC_RF, RFReq_WarpID_OC_RF, RFReq_Addr_OC_RF,
             Valid_OC_ALU, ActiveMask_OC_ALU, WarpID_OC_ALU, Instr_OC_ALU,
             Src1_Data_OC_ALU, Src2_Data_OC_ALU, Dst_OC_ALU, Imme_OC_ALU,
             Imme_Valid_OC_ALU, RegWrite_OC_ALU, ALUop_OC_ALU,
             BEQ_OC_ALU, BLT_OC_ALU, ScbID_OC_ALU
   );
endinterface

// File: rtl/oc_alu_collector.sv
// ALU operand collector: NUM_ENTRIES entries share one RF read port and dispatch to the ALU.
// Optional OC_R0_ZERO_EN: sources naming R0 are satisfied with zero at allocation.
module oc_alu_collector #(
   parameter int NUM_ENTRIES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   oc_alu_collector_if.master         bus,
   output logic [2*NUM_ENTRIES-1:0]   dbg_state_o
);
   localparam int IDX_W = (NUM_ENTRIES > 2) ? 2 : 1;

   typedef enum logic [1:0] {EMPTY = 2'd0, COLLECT = 2'd1, READY = 2'd2} ent_state_e;

   typedef struct packed {
      logic [2:0]   warp;
      logic [31:0]  instr;
      logic [7:0]   mask;
      logic [4:0]   src1;
      logic [4:0]   src2;
      logic         need1;
      logic         need2;
      logic         pend1;
      logic         pend2;
      logic [4:0]   dst;
      logic [15:0]  imme;
      logic         imme_valid;
      logic         regwrite;
      logic [3:0]   aluop;
      logic         beq;
      logic         blt;
      logic [1:0]   scb;
      logic [255:0] data1;
      logic [255:0] data2;
   } entry_t;

   typedef struct packed {
      logic [7:0]   mask;
      logic [2:0]   warp;
      logic [31:0]  instr;
      logic [255:0] data1;
      logic [255:0] data2;
      logic [4:0]   dst;
      logic [15:0]  imme;
      logic         imme_valid;
      logic         regwrite;
      logic [3:0]   aluop;
      logic         beq;
      logic         blt;
      logic [1:0]   scb;
   } alu_out_t;

   ent_state_e       state_q [NUM_ENTRIES];
   ent_state_e       state_d [NUM_ENTRIES];
   entry_t           ent_q   [NUM_ENTRIES];
   entry_t           ent_d   [NUM_ENTRIES];
   logic [IDX_W-1:0] rr_q, rr_d;
   logic [IDX_W-1:0] dp_q, dp_d;
   logic             tag_valid_q, tag_valid_d;
   logic [IDX_W-1:0] tag_idx_q, tag_idx_d;
   logic             tag_op_q, tag_op_d;
   alu_out_t         alu_q, alu_d;
   logic             alu_valid_q, alu_valid_d;

   logic             free_found;
   logic [IDX_W-1:0] free_idx;
   logic             req_found;
   logic [IDX_W-1:0] req_idx;
   logic             req_op;
   logic             dsp_found;
   logic [IDX_W-1:0] dsp_idx;
   logic [IDX_W-1:0] cand;
   logic             skip1, skip2;
   entry_t           new_ent;

`ifdef OC_R0_ZERO_EN
   assign skip1 = (bus.Src1_IB_OC == 5'd0);
   assign skip2 = (bus.Src2_IB_OC == 5'd0);
`else
   assign skip1 = 1'b0;
   assign skip2 = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      ent_d       = ent_q;
      rr_d        = rr_q;
      dp_d        = dp_q;
      tag_valid_d = 1'b0;
      tag_idx_d   = tag_idx_q;
      tag_op_d    = tag_op_q;
      alu_d       = alu_q;
      alu_valid_d = 1'b0;
      free_found  = 1'b0;
      free_idx    = '0;
      req_found   = 1'b0;
      req_idx     = '0;
      req_op      = 1'b0;
      dsp_found   = 1'b0;
      dsp_idx     = '0;
      cand        = '0;
      new_ent     = '0;

      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (!free_found && state_q[i] == EMPTY) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end

      // Read arbitration: round-robin over entries, src1 ahead of src2 within one.
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         cand = IDX_W'((int'(rr_q) + i) % NUM_ENTRIES);
         if (!req_found && state_q[cand] == COLLECT) begin
            if (ent_q[cand].need1 && !ent_q[cand].pend1) begin
               req_found = 1'b1;
               req_idx   = cand;
               req_op    = 1'b0;
            end else if (ent_q[cand].need2 && !ent_q[cand].pend2) begin
               req_found = 1'b1;
               req_idx   = cand;
               req_op    = 1'b1;
            end
         end
      end

      if (req_found && bus.RFGrant_RF_OC) begin
         tag_valid_d = 1'b1;
         tag_idx_d   = req_idx;
         tag_op_d    = req_op;
         if (req_op) ent_d[req_idx].pend2 = 1'b1;
         else        ent_d[req_idx].pend1 = 1'b1;
         rr_d = IDX_W'((int'(req_idx) + 1) % NUM_ENTRIES);
      end

      if (tag_valid_q) begin
         if (tag_op_q) begin
            ent_d[tag_idx_q].data2 = bus.RFRsp_Data_RF_OC;
            ent_d[tag_idx_q].need2 = 1'b0;
            ent_d[tag_idx_q].pend2 = 1'b0;
         end else begin
            ent_d[tag_idx_q].data1 = bus.RFRsp_Data_RF_OC;
            ent_d[tag_idx_q].need1 = 1'b0;
            ent_d[tag_idx_q].pend1 = 1'b0;
         end
         if (!ent_d[tag_idx_q].need1 && !ent_d[tag_idx_q].need2)
            state_d[tag_idx_q] = READY;
      end

      for (int i = 0; i < NUM_ENTRIES; i++) begin
         cand = IDX_W'((int'(dp_q) + i) % NUM_ENTRIES);
         if (!dsp_found && state_q[cand] == READY) begin
            dsp_found = 1'b1;
            dsp_idx   = cand;
         end
      end

      if (dsp_found) begin
         alu_valid_d      = 1'b1;
         alu_d.mask       = ent_q[dsp_idx].mask;
         alu_d.warp       = ent_q[dsp_idx].warp;
         alu_d.instr      = ent_q[dsp_idx].instr;
         alu_d.data1      = ent_q[dsp_idx].data1;
         alu_d.data2      = ent_q[dsp_idx].data2;
         alu_d.dst        = ent_q[dsp_idx].dst;
         alu_d.imme       = ent_q[dsp_idx].imme;
         alu_d.imme_valid = ent_q[dsp_idx].imme_valid;
         alu_d.regwrite   = ent_q[dsp_idx].regwrite;
         alu_d.aluop      = ent_q[dsp_idx].aluop;
         alu_d.beq        = ent_q[dsp_idx].beq;
         alu_d.blt        = ent_q[dsp_idx].blt;
         alu_d.scb        = ent_q[dsp_idx].scb;
         state_d[dsp_idx] = EMPTY;
         dp_d             = IDX_W'((int'(dsp_idx) + 1) % NUM_ENTRIES);
      end

      // The allocated slot is EMPTY now, so it never collides with dispatch or a response.
      if (bus.Valid_IB_OC && free_found) begin
         new_ent.warp       = bus.WarpID_IB_OC;
         new_ent.instr      = bus.Instr_IB_OC;
         new_ent.mask       = bus.ActiveMask_IB_OC;
         new_ent.src1       = bus.Src1_IB_OC;
         new_ent.src2       = bus.Src2_IB_OC;
         new_ent.need1      = bus.Src1_Used_IB_OC & ~skip1;
         new_ent.need2      = bus.Src2_Used_IB_OC & ~skip2;
         new_ent.dst        = bus.Dst_IB_OC;
         new_ent.imme       = bus.Imme_IB_OC;
         new_ent.imme_valid = bus.Imme_Valid_IB_OC;
         new_ent.regwrite   = bus.RegWrite_IB_OC;
         new_ent.aluop      = bus.ALUop_IB_OC;
         new_ent.beq        = bus.BEQ_IB_OC;
         new_ent.blt        = bus.BLT_IB_OC;
         new_ent.scb        = bus.ScbID_IB_OC;
         ent_d[free_idx]    = new_ent;
         state_d[free_idx]  = (new_ent.need1 || new_ent.need2) ? COLLECT : READY;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_q[i] <= EMPTY;
            ent_q[i]   <= '0;
         end
         rr_q        <= '0;
         dp_q        <= '0;
         tag_valid_q <= 1'b0;
         tag_idx_q   <= '0;
         tag_op_q    <= 1'b0;
         alu_q       <= '0;
         alu_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ent_q       <= ent_d;
         rr_q        <= rr_d;
         dp_q        <= dp_d;
         tag_valid_q <= tag_valid_d;
         tag_idx_q   <= tag_idx_d;
         tag_op_q    <= tag_op_d;
         alu_q       <= alu_d;
         alu_valid_q <= alu_valid_d;
      end
   end

   always_comb begin
      dbg_state_o = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) dbg_state_o[2*i +: 2] = state_q[i];
   end

   assign bus.Ready_OC_IB        = free_found;
   assign bus.RFReq_Valid_OC_RF  = req_found;
   assign bus.RFReq_WarpID_OC_RF = ent_q[req_idx].warp;
   assign bus.RFReq_Addr_OC_RF   = req_op ? ent_q[req_idx].src2 : ent_q[req_idx].src1;

   assign bus.Valid_OC_ALU      = alu_valid_q;
   assign bus.ActiveMask_OC_ALU = alu_q.mask;
   assign bus.WarpID_OC_ALU     = alu_q.warp;
   assign bus.Instr_OC_ALU      = alu_q.instr;
   assign bus.Src1_Data_OC_ALU  = alu_q.data1;
   assign bus.Src2_Data_OC_ALU  = alu_q.data2;
   assign bus.Dst_OC_ALU        = alu_q.dst;
   assign bus.Imme_OC_ALU       = alu_q.imme;
   assign bus.Imme_Valid_OC_ALU = alu_q.imme_valid;
   assign bus.RegWrite_OC_ALU   = alu_q.regwrite;
   assign bus.ALUop_OC_ALU      = alu_q.aluop;
   assign bus.BEQ_OC_ALU        = alu_q.beq;
   assign bus.BLT_OC_ALU        = alu_q.blt;
   assign bus.ScbID_OC_ALU      = alu_q.scb;
endmodule

// File: doc/oc_alu_collector.md
Name: oc_alu_collector

Overview:
- Operand collector feeding the ALU. Accepts ALU-class instructions (ALU ops, BEQ, BLT) from the issue stage into NUM_ENTRIES collector entries.
- Reads source registers through one shared register-file read port and dispatches fully collected entries to the ALU on the OC→ALU interface. It is the transmitting end of that interface.
- The ALU has no backpressure, so every dispatch is fire-and-forget.

Parameters:
NUM_ENTRIES, 2, number of collector entries (legal: 2 or 4)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
Valid_IB_OC  input  1  issue request
Ready_OC_IB  output  1  at least one entry EMPTY (combinational)
WarpID_IB_OC  input  3  warp ID
Instr_IB_OC  input  32  instruction word
ActiveMask_IB_OC  input  8  lane mask
Src1_IB_OC  input  5  source 1 register
Src1_Used_IB_OC  input  1  source 1 must be read
Src2_IB_OC  input  5  source 2 register
Src2_Used_IB_OC  input  1  source 2 must be read
Dst_IB_OC  input  5  destination register
Imme_IB_OC  input  16  immediate
Imme_Valid_IB_OC  input  1  immediate replaces source 2
RegWrite_IB_OC  input  1  writes a register
ALUop_IB_OC  input  4  ALU opcode
BEQ_IB_OC  input  1  BEQ
BLT_IB_OC  input  1  BLT
ScbID_IB_OC  input  2  scoreboard entry ID
RFReq_Valid_OC_RF  output  1  read request
RFReq_WarpID_OC_RF  output  3  read warp
RFReq_Addr_OC_RF  output  5  read register
RFGrant_RF_OC  input  1  request accepted this cycle
RFRsp_Data_RF_OC  input  256  read data, valid the cycle after a grant
Valid_OC_ALU  output  1  dispatch strobe (registered)
ActiveMask_OC_ALU  output  8  registered
WarpID_OC_ALU  output  3  registered
Instr_OC_ALU  output  32  registered
Src1_Data_OC_ALU  output  256  registered
Src2_Data_OC_ALU  output  256  registered
Dst_OC_ALU  output  5  registered
Imme_OC_ALU  output  16  registered
Imme_Valid_OC_ALU  output  1  registered
RegWrite_OC_ALU  output  1  registered
ALUop_OC_ALU  output  4  registered
BEQ_OC_ALU  output  1  registered
BLT_OC_ALU  output  1  registered
ScbID_OC_ALU  output  2  registered

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous active-low.
- Reset values:
  - all entries EMPTY; read tag invalid; arbitration and dispatch pointers at 0;
  - every registered output 0, including Valid_OC_ALU;
  - Ready_OC_IB reads 1 once rst is released.
- Allocation:
  - on Valid_IB_OC & Ready_OC_IB at a clock edge, fields are captured into the lowest-index EMPTY entry;
  - need1 = Src1_Used; need2 = Src2_Used; operand data cleared to 0;
  - state becomes READY if neither source is needed, otherwise COLLECT.
- Entry states: EMPTY → COLLECT → READY → EMPTY.
- Read arbitration:
  - each cycle, one COLLECT entry with an un-requested needed operand drives the RF request;
  - entries are chosen round-robin, and within an entry src1 goes before src2;
  - RFReq_Valid_OC_RF = 0 when no request is pending;
  - if RFGrant_RF_OC is 0, nothing is recorded; arbitration is repeated next cycle and the pointer does not advance;
  - on grant, the (entry, operand) tag is registered and the pointer advances past the granted entry;
  - the cycle after a grant, RFRsp_Data_RF_OC is written into the tagged slot and its need bit clears;
  - a new request may be granted in the same cycle a response returns (one read in flight per cycle, fully pipelined).
- COLLECT → READY at the edge where the last needed operand is written.
- Dispatch:
  - each cycle, at most one READY entry is selected round-robin;
  - at the edge, its fields load into the output registers with Valid_OC_ALU = 1, and the entry becomes EMPTY;
  - with no READY entry, Valid_OC_ALU = 0 and the data outputs hold their previous values;
  - Src*_Data of unused operands is 0.
- Latency, allocation edge to Valid_OC_ALU with grants always given:
  - 0 sources: 1 cycle;
  - 1 source: 3 cycles;
  - 2 sources: 4 cycles.
- Simultaneous events:
  - allocation and dispatch in the same cycle are legal;
  - an entry freed by dispatch is allocatable from the next cycle (Ready_OC_IB is computed from current state only);
  - an entry cannot dispatch in the cycle it is allocated.
- Full: Ready_OC_IB = 0; Valid_IB_OC is ignored.
- Reset mid-operation: all entries are discarded, the in-flight read tag is cleared, and the RF response in the following cycle is ignored.

Optional Feature:
- Macro OC_R0_ZERO_EN.
- Defined: a needed source with register index 0 is satisfied at allocation with data 0 and never generates an RF request. An instruction whose used sources are all R0 becomes READY immediately.
- Undefined: R0 is read from the RF like any other register.

Test Plan:
- ADD r3=r1+r2, warp 2, grant always 1, RF returns 0x11 per lane then 0x22 → one Valid_OC_ALU pulse 4 cycles after allocation; Src1 = {8{32'h11}}, Src2 = {8{32'h22}}, Dst = 3, WarpID = 2.
- ADDI (Src2_Used = 0, Imme = 16'hFFFF, Imme_Valid = 1) → one RF request; Src2_Data = 0; Imme_OC_ALU = FFFF; latency 3.
- Fill both entries, hold Valid_IB_OC = 1 → Ready_OC_IB = 0 until the first dispatch edge; third instruction accepted on the next edge; dispatch order is 0, 1, then the new one.
- RFGrant_RF_OC = 0 for 5 cycles → request held stable (same warp/addr), no dispatch; grant released → dispatch 4 cycles later.
- Assert rst low while a response is due → all outputs 0, Ready_OC_IB = 1 after release, and no dispatch occurs from the stale response.
- OC_R0_ZERO_EN defined, BEQ r0, r5 → single RF read (addr 5); Src1_Data = 0; BEQ_OC_ALU = 1; latency 3.
